tlb_translate: RTL and testbench

//   Fully associative joint TLB directly downstream of the memory map stage. It takes addresses flagged using_tlb
//   (useg/kseg2/kseg3) and returns a registered physical address plus refill/invalid/modified status, one cycle later.
//   It also services TLBWI/TLBWR/TLBR/TLBP from CP0 and maintains the Random register against Wired.

---
 rtl/tlb_translate_pkg.sv | 45 ++++
 rtl/tlb_translate_match.sv | 15 +
 rtl/tlb_translate.sv | 182 ++++++++++++++++++
 tb/tb_tlb_translate.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_translate_pkg.sv
// Shared TLB field layout (EntryHi/EntryLo bit positions), entry storage type and CP0 packing helpers.
package tlb_translate_pkg;

  localparam int HI_VPN2_HI = 31;
  localparam int HI_VPN2_LO = 13;
  localparam int HI_ASID_HI = 7;
  localparam int HI_ASID_LO = 0;

  localparam int LO_PFN_HI = 25;
  localparam int LO_PFN_LO = 6;
  localparam int LO_C_HI   = 5;
  localparam int LO_C_LO   = 3;
  localparam int LO_D      = 2;
  localparam int LO_V      = 1;
  localparam int LO_G      = 0;

  localparam logic [2:0] C_UNCACHED = 3'd2;

  typedef struct packed {
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } tlb_lo_t;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    tlb_lo_t     lo0;
    tlb_lo_t     lo1;
  } tlb_entry_t;

  localparam tlb_entry_t ENTRY_CLEAR = '0;

  // G lives once per entry but is reported in both EntryLo words.
  function automatic logic [31:0] pack_lo(input tlb_lo_t lo, input logic g);
    return {6'b000000, lo.pfn, lo.c, lo.d, lo.v, g};
  endfunction

  function automatic logic [31:0] pack_hi(input logic [18:0] vpn2, input logic [7:0] asid);
    return {vpn2, 5'b00000, asid};
  endfunction

endpackage

// File: rtl/tlb_translate_match.sv
// One TLB entry's tag compare: VPN2 equality plus global-or-ASID match.
module tlb_translate_match
  import tlb_translate_pkg::*;
(
  input  logic [18:0] entry_vpn2,
  input  logic [7:0]  entry_asid,
  input  logic        entry_g,
  input  logic [18:0] vpn2,
  input  logic [7:0]  asid,
  output logic        hit
);

  assign hit = (entry_vpn2 == vpn2) && (entry_g || (entry_asid == asid));

endmodule

// File: rtl/tlb_translate.sv
// Fully associative joint TLB: 1-cycle registered lookup, CP0 TLBWI/TLBWR/TLBR/TLBP and Random register.
// Optional feature: define TLB_MISS_COUNT_EN to add the saturating miss_count output.
module tlb_translate
  import tlb_translate_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [31:0]      req_vaddr,
  input  logic             req_store,
  input  logic [7:0]       cur_asid,
  output logic             resp_valid,
  output logic [31:0]      resp_paddr,
  output logic             resp_miss,
  output logic             resp_invalid,
  output logic             resp_modified,
  output logic             resp_uncached,
  input  logic             tlbwi,
  input  logic             tlbwr,
  input  logic             tlbr,
  input  logic             tlbp,
  input  logic [IDX_W-1:0] cp0_index,
  input  logic [IDX_W-1:0] cp0_wired,
  input  logic             wired_we,
  input  logic [31:0]      cp0_entryhi,
  input  logic [31:0]      cp0_entrylo0,
  input  logic [31:0]      cp0_entrylo1,
  output logic             rd_valid,
  output logic [31:0]      rd_entryhi,
  output logic [31:0]      rd_entrylo0,
  output logic [31:0]      rd_entrylo1,
  output logic [31:0]      probe_index,
  output logic [IDX_W-1:0] random_o
`ifdef TLB_MISS_COUNT_EN
  ,
  output logic [31:0]      miss_count
`endif
);

  localparam logic [IDX_W-1:0] RAND_MAX = IDX_W'(NUM_ENTRIES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  tlb_entry_t             tlb [NUM_ENTRIES];
  tlb_entry_t             wr_entry;
  logic [NUM_ENTRIES-1:0] lk_hit;
  logic [NUM_ENTRIES-1:0] pr_hit;
  logic                   lk_found;
  logic                   pr_found;
  logic [IDX_W-1:0]       lk_idx;
  logic [IDX_W-1:0]       pr_idx;
  tlb_lo_t                lk_lo;
  logic                   lk_ok;
  logic                   unused_bits;

  assign unused_bits = ^{cp0_entryhi[12:8], cp0_entrylo0[31:26], cp0_entrylo1[31:26]};

  assign wr_entry = '{
    vpn2: cp0_entryhi[HI_VPN2_HI:HI_VPN2_LO],
    asid: cp0_entryhi[HI_ASID_HI:HI_ASID_LO],
    g:    cp0_entrylo0[LO_G] & cp0_entrylo1[LO_G],
    lo0:  '{pfn: cp0_entrylo0[LO_PFN_HI:LO_PFN_LO], c: cp0_entrylo0[LO_C_HI:LO_C_LO],
            d: cp0_entrylo0[LO_D], v: cp0_entrylo0[LO_V]},
    lo1:  '{pfn: cp0_entrylo1[LO_PFN_HI:LO_PFN_LO], c: cp0_entrylo1[LO_C_HI:LO_C_LO],
            d: cp0_entrylo1[LO_D], v: cp0_entrylo1[LO_V]}
  };

  for (genvar e = 0; e < NUM_ENTRIES; e++) begin : g_match
    tlb_translate_match u_lookup (
      .entry_vpn2(tlb[e].vpn2), .entry_asid(tlb[e].asid), .entry_g(tlb[e].g),
      .vpn2(req_vaddr[31:13]), .asid(cur_asid), .hit(lk_hit[e])
    );
    tlb_translate_match u_probe (
      .entry_vpn2(tlb[e].vpn2), .entry_asid(tlb[e].asid), .entry_g(tlb[e].g),
      .vpn2(cp0_entryhi[HI_VPN2_HI:HI_VPN2_LO]), .asid(cp0_entryhi[HI_ASID_HI:HI_ASID_LO]),
      .hit(pr_hit[e])
    );
  end

  // Priority encode hits; scanning downward lets the lowest matching index win.
  always_comb begin
    lk_found = 1'b0;
    pr_found = 1'b0;
    lk_idx   = {IDX_W{1'b0}};
    pr_idx   = {IDX_W{1'b0}};
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      lk_found = lk_found | lk_hit[i];
      pr_found = pr_found | pr_hit[i];
      lk_idx   = lk_hit[i] ? IDX_W'(i) : lk_idx;
      pr_idx   = pr_hit[i] ? IDX_W'(i) : pr_idx;
    end
  end

  // Select the even/odd page half and decide whether the access completes without a fault.
  always_comb begin
    lk_lo = req_vaddr[12] ? tlb[lk_idx].lo1 : tlb[lk_idx].lo0;
    lk_ok = lk_found & lk_lo.v & ~(req_store & ~lk_lo.d);
  end

  // Entry storage; a write becomes visible only after the edge, so same-cycle lookups see old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) tlb[i] <= ENTRY_CLEAR;
    end else if (tlbwi) begin
      tlb[cp0_index] <= wr_entry;
    end else if (tlbwr) begin
      tlb[random_o] <= wr_entry;
    end
  end

  // Random counts down to Wired then wraps to the top; Wired writes restart it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      random_o <= RAND_MAX;
    end else if (wired_we || (cp0_wired >= RAND_MAX) || (random_o <= cp0_wired)) begin
      random_o <= RAND_MAX;
    end else begin
      random_o <= random_o - IDX_ONE;
    end
  end

  // Registered lookup response; everything forced to zero on idle cycles and faults.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid    <= 1'b0;
      resp_paddr    <= 32'd0;
      resp_miss     <= 1'b0;
      resp_invalid  <= 1'b0;
      resp_modified <= 1'b0;
      resp_uncached <= 1'b0;
    end else if (req_valid) begin
      resp_valid    <= 1'b1;
      resp_paddr    <= lk_ok ? {lk_lo.pfn, req_vaddr[11:0]} : 32'd0;
      resp_miss     <= ~lk_found;
      resp_invalid  <= lk_found & ~lk_lo.v;
      resp_modified <= lk_found & lk_lo.v & req_store & ~lk_lo.d;
      resp_uncached <= lk_ok & (lk_lo.c == C_UNCACHED);
    end else begin
      resp_valid    <= 1'b0;
      resp_paddr    <= 32'd0;
      resp_miss     <= 1'b0;
      resp_invalid  <= 1'b0;
      resp_modified <= 1'b0;
      resp_uncached <= 1'b0;
    end
  end

  // TLBR/TLBP results; data registers hold their last value between requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid    <= 1'b0;
      rd_entryhi  <= 32'd0;
      rd_entrylo0 <= 32'd0;
      rd_entrylo1 <= 32'd0;
      probe_index <= 32'd0;
    end else if (tlbp) begin
      rd_valid    <= 1'b1;
      probe_index <= {~pr_found, {(31 - IDX_W){1'b0}}, pr_found ? pr_idx : {IDX_W{1'b0}}};
    end else if (tlbr) begin
      rd_valid    <= 1'b1;
      rd_entryhi  <= pack_hi(tlb[cp0_index].vpn2, tlb[cp0_index].asid);
      rd_entrylo0 <= pack_lo(tlb[cp0_index].lo0, tlb[cp0_index].g);
      rd_entrylo1 <= pack_lo(tlb[cp0_index].lo1, tlb[cp0_index].g);
    end else begin
      rd_valid    <= 1'b0;
    end
  end

`ifdef TLB_MISS_COUNT_EN
  // Saturating refill counter, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_count <= 32'd0;
    end else if (req_valid && !lk_found && (miss_count != 32'hFFFF_FFFF)) begin
      miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tlb_translate.sv
// Scoreboard bench for tlb_translate: directed scenarios then randomized traffic vs a reference model.
module tb_tlb_translate;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_store = 1'b0;
  logic [31:0] req_vaddr = 32'd0;
  logic [7:0] cur_asid = 8'd0;
  logic tlbwi = 1'b0, tlbwr = 1'b0, tlbr = 1'b0, tlbp = 1'b0, wired_we = 1'b0;
  logic [3:0] cp0_index = 4'd0, cp0_wired = 4'd0;
  logic [31:0] cp0_entryhi = 32'd0, cp0_entrylo0 = 32'd0, cp0_entrylo1 = 32'd0;
  logic resp_valid, resp_miss, resp_invalid, resp_modified, resp_uncached, rd_valid;
  logic [31:0] resp_paddr, rd_entryhi, rd_entrylo0, rd_entrylo1, probe_index;
  logic [3:0] random_o;
`ifdef TLB_MISS_COUNT_EN
  logic [31:0] miss_count;
`endif

  tlb_translate #(.NUM_ENTRIES(16), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_vaddr(req_vaddr), .req_store(req_store),
    .cur_asid(cur_asid), .resp_valid(resp_valid), .resp_paddr(resp_paddr), .resp_miss(resp_miss),
    .resp_invalid(resp_invalid), .resp_modified(resp_modified), .resp_uncached(resp_uncached),
    .tlbwi(tlbwi), .tlbwr(tlbwr), .tlbr(tlbr), .tlbp(tlbp), .cp0_index(cp0_index),
    .cp0_wired(cp0_wired), .wired_we(wired_we), .cp0_entryhi(cp0_entryhi),
    .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1), .rd_valid(rd_valid),
    .rd_entryhi(rd_entryhi), .rd_entrylo0(rd_entrylo0), .rd_entrylo1(rd_entrylo1),
    .probe_index(probe_index), .random_o(random_o)
`ifdef TLB_MISS_COUNT_EN
    , .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] paddr;
    logic miss, inv, modf, unc;
  } resp_t;
  typedef struct packed {
    logic probe;
    logic [31:0] hi, lo0, lo1, pidx;
  } rd_t;

  resp_t rq[$];
  rd_t dq[$];
  logic [31:0] mhi[N], mlo0[N], mlo1[N];
  int r_cur, exp_random, exp_miss;
  bit checking = 1'b0;
  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an entry is just the three CP0 words as written.
  function automatic int find(input logic [18:0] vpn2, input logic [7:0] asid);
    for (int i = 0; i < N; i++)
      if (mhi[i][31:13] == vpn2 && ((mlo0[i][0] & mlo1[i][0]) || mhi[i][7:0] == asid)) return i;
    return -1;
  endfunction

  function automatic resp_t model_lookup(input logic [31:0] va, input logic st, input logic [7:0] asid);
    resp_t r;
    logic [31:0] lo;
    int i;
    r = '0;
    i = find(va[31:13], asid);
    if (i < 0) r.miss = 1'b1;
    else begin
      lo = va[12] ? mlo1[i] : mlo0[i];
      if (!lo[1]) r.inv = 1'b1;
      else if (st && !lo[2]) r.modf = 1'b1;
      else begin
        r.paddr = {lo[25:6], va[11:0]};
        r.unc = (lo[5:3] == 3'd2);
      end
    end
    return r;
  endfunction

  function automatic rd_t model_rd(input bit probe);
    rd_t d;
    int i;
    logic g;
    d = '0;
    d.probe = probe;
    if (probe) begin
      i = find(cp0_entryhi[31:13], cp0_entryhi[7:0]);
      d.pidx = (i < 0) ? 32'h8000_0000 : i;
    end else begin
      g = mlo0[cp0_index][0] & mlo1[cp0_index][0];
      d.hi  = mhi[cp0_index] & 32'hFFFF_E0FF;
      d.lo0 = (mlo0[cp0_index] & 32'h03FF_FFFE) | {31'd0, g};
      d.lo1 = (mlo1[cp0_index] & 32'h03FF_FFFE) | {31'd0, g};
    end
    return d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin mhi[i] = 0; mlo0[i] = 0; mlo1[i] = 0; end
    r_cur = N - 1; exp_random = N - 1; exp_miss = 0;
    rq.delete(); dq.delete();
  endtask

  // One clock of stimulus: expectations from pre-write state, then model update, then the edge.
  task automatic step();
    resp_t e;
    rd_t d;
    bit do_resp, do_rd;
    int w, nxt;
    do_resp = req_valid;
    do_rd = tlbp | tlbr;
    e = model_lookup(req_vaddr, req_store, cur_asid);
    d = model_rd(tlbp);
    w = tlbwi ? int'(cp0_index) : r_cur;
    if (tlbwi || tlbwr) begin mhi[w] = cp0_entryhi; mlo0[w] = cp0_entrylo0; mlo1[w] = cp0_entrylo1; end
    // Random walks N-1 down to Wired, then wraps.
    if (wired_we || cp0_wired >= N - 1 || r_cur == int'(cp0_wired)) nxt = N - 1;
    else nxt = r_cur - 1;
    @(posedge clk);
    if (do_resp) begin rq.push_back(e); if (e.miss) exp_miss++; end
    if (do_rd) dq.push_back(d);
    r_cur = nxt;
    exp_random = nxt;
    #1;
    req_valid = 0; req_store = 0; tlbwi = 0; tlbwr = 0; tlbr = 0; tlbp = 0; wired_we = 0;
  endtask

  task automatic do_write(input int idx, input logic [31:0] hi, lo0, lo1, input bit rnd);
    tlbwi = !rnd; tlbwr = rnd; cp0_index = 4'(idx);
    cp0_entryhi = hi; cp0_entrylo0 = lo0; cp0_entrylo1 = lo1;
    step();
  endtask

  task automatic do_lookup(input logic [31:0] va, input logic st, input logic [7:0] asid);
    req_valid = 1; req_vaddr = va; req_store = st; cur_asid = asid;
    step();
  endtask

  // Monitor: pops expectations whenever the DUT presents a result.
  always @(negedge clk) begin
    resp_t e;
    rd_t d;
    if (checking) begin
      chk("random", {28'd0, random_o}, exp_random);
`ifdef TLB_MISS_COUNT_EN
      chk("miss_count", miss_count, exp_miss);
`endif
      if (resp_valid) begin
        if (rq.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
        else begin
          e = rq.pop_front();
          chk("resp_paddr", resp_paddr, e.paddr);
          chk("resp_flags", {28'd0, resp_miss, resp_invalid, resp_modified, resp_uncached},
              {28'd0, e.miss, e.inv, e.modf, e.unc});
        end
      end else begin
        if (rq.size() != 0) begin chk("resp_missing", 32'd0, 32'd1); void'(rq.pop_front()); end
        chk("resp_idle_zero", {27'd0, resp_miss, resp_invalid, resp_modified, resp_uncached, |resp_paddr}, 32'd0);
      end
      if (rd_valid) begin
        if (dq.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
        else begin
          d = dq.pop_front();
          if (d.probe) chk("probe_index", probe_index, d.pidx);
          else begin
            chk("rd_entryhi", rd_entryhi, d.hi);
            chk("rd_entrylo0", rd_entrylo0, d.lo0);
            chk("rd_entrylo1", rd_entrylo1, d.lo1);
          end
        end
      end else if (dq.size() != 0) begin
        chk("rd_missing", 32'd0, 32'd1);
        void'(dq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] va, hi;
    int op;
    model_reset();
    #12;
    chk("reset_outputs", {resp_valid, resp_miss, resp_invalid, resp_modified, resp_uncached, rd_valid, 26'd0}, 32'd0);
    chk("reset_paddr_probe", resp_paddr | probe_index | rd_entryhi, 32'd0);
    chk("reset_random", {28'd0, random_o}, 32'd15);
    @(posedge clk); #1;
    rst = 0;
    checking = 1;

    // Basic translation, ASID mismatch, global entry, invalid odd page, modified store.
    do_write(3, 32'h0040_0005, (32'h12345 << 6) | 32'h6, 32'h0, 1'b0);
    do_lookup(32'h0040_0ABC, 1'b0, 8'd5);
    do_lookup(32'h0040_0ABC, 1'b0, 8'd6);
    do_write(3, 32'h0040_0005, (32'h12345 << 6) | 32'h7, 32'h1, 1'b0);
    do_lookup(32'h0040_0ABC, 1'b0, 8'd6);
    do_lookup(32'h0040_1000, 1'b0, 8'd5);
    do_write(3, 32'h0040_0005, (32'h12345 << 6) | 32'h12, 32'h0, 1'b0);
    do_lookup(32'h0040_0ABC, 1'b1, 8'd5);
    do_lookup(32'h0040_0ABC, 1'b0, 8'd5);

    // Probe absent/present, read back, write+lookup same cycle sees old data.
    cp0_entryhi = 32'h7770_0005; tlbp = 1; step();
    cp0_entryhi = 32'h0040_0005; tlbp = 1; step();
    cp0_index = 4'd3; tlbr = 1; tlbp = 1; step();
    cp0_index = 4'd3; tlbr = 1; step();
    req_valid = 1; req_vaddr = 32'h0040_0123; cur_asid = 8'd5;
    tlbwi = 1; cp0_index = 4'd3; cp0_entryhi = 32'h0040_0005; cp0_entrylo0 = (32'h0ABCD << 6) | 32'h6;
    cp0_entrylo1 = 32'h0; step();
    do_lookup(32'h0040_0123, 1'b0, 8'd5);

    // Wired=4: full wrap, tlbwr at current Random, mid-count Wired write.
    cp0_wired = 4'd4; wired_we = 1; step();
    for (int i = 0; i < 14; i++) step();
    do_write(0, 32'h0060_0009, (32'h0BEEF << 6) | 32'h16, 32'h3, 1'b1);
    for (int i = 0; i < 3; i++) step();
    wired_we = 1; step();
    cp0_index = 4'(r_cur); tlbr = 1; step();

    // Randomized traffic over a small VPN2 pool so hits, misses and duplicates all occur.
    for (int c = 0; c < 600; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      va = $urandom();
      req_vaddr = {13'h0020 + 13'($urandom_range(0, 5)), 6'd0, va[12:0]};
      req_store = $urandom_range(0, 1);
      cur_asid = 8'($urandom_range(5, 6));
      hi = $urandom();
      cp0_entryhi = {13'h0020 + 13'($urandom_range(0, 5)), 6'd0, hi[12:8], 8'($urandom_range(5, 6))};
      cp0_entrylo0 = $urandom();
      cp0_entrylo1 = $urandom();
      cp0_index = 4'($urandom_range(0, 15));
      op = $urandom_range(0, 11);
      case (op)
        0: tlbwi = 1;
        1: tlbwr = 1;
        2: tlbr = 1;
        3: tlbp = 1;
        4: begin tlbr = 1; tlbp = 1; end
        5: begin tlbwi = 1; tlbwr = 1; end
        6: begin wired_we = 1; cp0_wired = 4'($urandom_range(0, 15)); end
        default: ;
      endcase
      step();
    end

    // Reset during an in-flight lookup drops it immediately.
    checking = 0;
    req_valid = 1; req_vaddr = 32'h7FFF_F000; cur_asid = 8'd9;
    @(posedge clk); #1;
    req_valid = 0;
    chk("inflight_valid", {31'd0, resp_valid}, 32'd1);
    rst = 1;
    #1;
    chk("rst_resp_valid", {30'd0, resp_valid, rd_valid}, 32'd0);
    chk("rst_random", {28'd0, random_o}, 32'd15);
`ifdef TLB_MISS_COUNT_EN
    chk("rst_miss_count", miss_count, 32'd0);
`endif
    model_reset();
    cp0_wired = 4'd0;
    @(posedge clk); #1;
    rst = 0;
    checking = 1;
    do_lookup(32'h0040_0ABC, 1'b0, 8'd5);
    do_lookup(32'h0000_0ABC, 1'b0, 8'd0);
    do_write(1, 32'h0080_0001, (32'h00055 << 6) | 32'h16, 32'h2, 1'b0);
    do_lookup(32'h0080_0010, 1'b0, 8'd1);
    do_lookup(32'h0080_1010, 1'b1, 8'd1);
    do_lookup(32'h0090_0010, 1'b0, 8'd1);
    step(); step();
    chk("resp_drain", rq.size(), 32'd0);
    chk("rd_drain", dq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
